// File: rtl/fetch_pkg.sv
// ------------------------------------------------------------------
// fetch_pkg : state encoding and shared constants for ram_sample_fetch
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_t;

  localparam int unsigned DEFAULT_NUM_SAMPLES = 44100;
  localparam int unsigned RAM_RD_LATENCY      = 1;

endpackage

`default_nettype wire

// File: rtl/fetch_hold_reg.sv
// ------------------------------------------------------------------
// fetch_hold_reg : one-entry skid register for a returned RAM word
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_hold_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              unload,
  output logic              valid,
  output logic [DATA_W-1:0] data_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (unload) begin
      valid    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_sample_fetch.sv
// ------------------------------------------------------------------
// ram_sample_fetch : streams a sample block from RAM into the accelerator
// FIFO; define FETCH_WRAP_EN for continuous wrap-around streaming. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module ram_sample_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       NUM_SAMPLES = DEFAULT_NUM_SAMPLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              ram_read_enable,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_bus,
  output logic              fifo_put,
  output logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sample_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(NUM_SAMPLES - 1);

  fetch_state_t      state;
  logic              rd_pending;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              hold_load;
  logic              put_hold;
  logic              put_direct;
  logic              drained;
  logic              last_issue;
  logic              leave_fetch;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] next_count;

  // A read goes out only when the returning word is guaranteed a home:
  // nothing held and the FIFO currently accepting.
  assign ram_read_enable = (state == S_FETCH) && !hold_valid && !fifo_full;
  assign put_hold        = hold_valid && !fifo_full;
  assign put_direct      = rd_pending && !hold_valid && !fifo_full;
  assign hold_load       = rd_pending && fifo_full;
  assign fifo_put        = put_hold || put_direct;
  assign drained         = !hold_load && (!hold_valid || put_hold);
  assign last_issue      = ram_read_enable && (addr == LAST_ADDR);

  always_comb begin
    fifo_data = '0;
    if (hold_valid) begin
      fifo_data = hold_data;
    end else if (rd_pending) begin
      fifo_data = data_bus;
    end
  end

`ifdef FETCH_WRAP_EN
  localparam logic [ADDR_W-1:0] LAST_COUNT = ADDR_W'(NUM_SAMPLES - 1);

  assign next_addr   = (addr == LAST_ADDR) ? BASE_ADDR : addr + 1'b1;
  assign next_count  = (sample_count == LAST_COUNT) ? '0 : sample_count + 1'b1;
  assign leave_fetch = stop;
`else
  logic unused_stop;

  assign unused_stop = stop;
  assign next_addr   = addr + 1'b1;
  assign next_count  = sample_count + 1'b1;
  assign leave_fetch = last_issue;
`endif

  fetch_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .data_in  (data_bus),
    .unload   (put_hold),
    .valid    (hold_valid),
    .data_out (hold_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      addr         <= BASE_ADDR;
      rd_pending   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
    end else begin
      rd_pending <= ram_read_enable;
      done       <= 1'b0;
      if (fifo_put) begin
        sample_count <= next_count;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FETCH;
            busy         <= 1'b1;
            addr         <= BASE_ADDR;
            sample_count <= '0;
          end
        end
        S_FETCH: begin
          if (ram_read_enable) begin
            addr <= next_addr;
          end
          if (leave_fetch) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_sample_fetch.sv
// ------------------------------------------------------------------
// tb_ram_sample_fetch : directed + randomized bench for ram_sample_fetch
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ram_sample_fetch;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef FETCH_WRAP_EN
  localparam int unsigned N = 4;
`else
  localparam int unsigned N = 8;
`endif
  localparam logic [AW-1:0] BASE = 32'd0;
  localparam int MAXC = 80;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          fifo_full = 1'b0;
  logic [DW-1:0] data_bus = '0;
  logic          ram_read_enable;
  logic [AW-1:0] addr;
  logic          fifo_put;
  logic [DW-1:0] fifo_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] sample_count;

  logic [DW-1:0] mem [0:63];

  int checks = 0;
  int errors = 0;
  int first_put, last_put, done_cyc, first_strobe;
  int n_puts, n_strobes, n_done, stall_strobes;
  logic busy_c1;

  ram_sample_fetch #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BASE_ADDR   (BASE),
    .NUM_SAMPLES (N)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .ram_read_enable (ram_read_enable),
    .addr            (addr),
    .data_bus        (data_bus),
    .fifo_put        (fifo_put),
    .fifo_data       (fifo_data),
    .fifo_full       (fifo_full),
    .busy            (busy),
    .done            (done),
    .sample_count    (sample_count)
  );

  always #5 clk = ~clk;

  // Sample RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_read_enable) data_bus <= mem[addr[5:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_rd_en"}, ram_read_enable, 0);
    check({pfx, "_addr"}, addr, BASE);
    check({pfx, "_put"}, fifo_put, 0);
    check({pfx, "_fifo_data"}, fifo_data, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_count"}, sample_count, 0);
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < 64; i++) mem[i] = ramp ? DW'(i + 100) : $urandom;
  endtask

  // mode 0: never full; 1: full cycles 5..8; 2: full cycles 0..3; 3: random
  task automatic run_block(input int mode, input int restart_at);
    logic [DW-1:0] q[$];
    logic [AW-1:0] ea;
    bit stop_sent;
    q = {};
    stop_sent = 0;
    first_put = -1; last_put = -1; done_cyc = -1; first_strobe = -1;
    n_puts = 0; n_strobes = 0; n_done = 0; stall_strobes = 0; busy_c1 = 1'b0;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 0) || (cyc == restart_at);
      case (mode)
        1:       fifo_full = (cyc >= 5 && cyc <= 8);
        2:       fifo_full = (cyc < 4);
        3:       fifo_full = ($urandom_range(0, 3) == 0);
        default: fifo_full = 1'b0;
      endcase
      stop = 1'b0;
`ifdef FETCH_WRAP_EN
      if (!stop_sent && n_puts >= 10) begin
        stop = 1'b1;
        stop_sent = 1;
      end
`endif
      @(negedge clk);
      if (cyc == 1) busy_c1 = busy;
      if (ram_read_enable) begin
`ifdef FETCH_WRAP_EN
        ea = BASE + AW'(n_strobes % N);
`else
        ea = BASE + AW'(n_strobes);
`endif
        check("strobe_while_full", fifo_full, 0);
        check("strobe_addr", addr, ea);
        q.push_back(mem[ea[5:0]]);
        if (first_strobe < 0) first_strobe = cyc;
        if (mode == 1 && cyc >= 5 && cyc <= 9) stall_strobes++;
        n_strobes++;
      end
      if (fifo_put) begin
        check("put_while_full", fifo_full, 0);
        check("put_has_read", q.size() > 0, 1);
        if (q.size() > 0) check("put_data", fifo_data, q.pop_front());
        check("count_before_put", sample_count, n_puts % N);
        if (first_put < 0) first_put = cyc;
        last_put = cyc;
        n_puts++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
        check("count_at_done", sample_count, n_puts % N == 0 && n_puts > 0 && n_puts <= N ? N : n_puts % N);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    stop = 1'b0;
    fifo_full = 1'b0;
    check("block_finished", done_cyc >= 0, 1);
    check("queue_empty", q.size(), 0);
    check("done_after_last_put", done_cyc, last_put + 1);
    check("single_done", n_done, 1);
    check("puts_eq_strobes", n_puts, n_strobes);
  endtask

  initial begin
    int n;
    fill_mem(1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef FETCH_WRAP_EN
    fill_mem(0);
    run_block(0, -1);
    check("wrap_puts", n_puts, 12);
    check("wrap_first_put", first_put, 2);
    fill_mem(0);
    run_block(3, -1);
`else
    // Nominal ramp block
    run_block(0, -1);
    check("nom_first_strobe", first_strobe, 1);
    check("nom_busy_c1", busy_c1, 1);
    check("nom_first_put", first_put, 2);
    check("nom_last_put", last_put, 9);
    check("nom_done", done_cyc, 10);
    check("nom_puts", n_puts, N);

    // Full on the return cycle of sample 3 for four cycles
    run_block(1, -1);
    check("stall_strobes", stall_strobes, 0);
    check("stall_last_put", last_put, 14);
    check("stall_done", done_cyc, 15);
    check("stall_puts", n_puts, N);

    // Full before start
    run_block(2, -1);
    check("prefull_first_strobe", first_strobe, 4);
    check("prefull_first_put", first_put, 5);
    check("prefull_done", done_cyc, 13);

    // Second start mid-block is ignored
    run_block(0, 4);
    check("restart_puts", n_puts, N);
    check("restart_done", done_cyc, 10);

    // Reset after five puts
    fill_mem(0);
    n = 0;
    for (int cyc = 0; cyc < MAXC && n < 5; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == 0);
      @(negedge clk);
      if (fifo_put) n++;
    end
    check("puts_before_reset", n, 5);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    check("midrst_no_put", fifo_put, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_block(0, -1);
    check("after_rst_first_strobe", first_strobe, 1);
    check("after_rst_puts", n_puts, N);

    // Randomized backpressure with random contents
    for (int r = 0; r < 3; r++) begin
      fill_mem(0);
      run_block(3, -1);
      check("rand_puts", n_puts, N);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
